// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state encoding, default parameters and coefficient field layout
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OUT  = 2'd3
    } alu_state_e;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_GUARD_W     = 8;
    localparam int DEF_ACC_W       = 40;
    localparam int DEF_DATA_DEPTH  = 256;
    localparam int DEF_COEFF_DEPTH = 512;
    localparam int DEF_N_RJ        = 16;
    localparam int DEF_CHANNELS    = 2;

    // Delay k occupies the low bits of a coefficient word; the sign bit sits directly above it.
    localparam int COEFF_K_LSB = 0;

endpackage

// File: rtl/pot_addsub.sv
// rtl/pot_addsub.sv - sign-extending add/subtract of a sample into the accumulator top field
module pot_addsub
    import alu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int GUARD_W = DEF_GUARD_W
) (
    input  logic [DATA_W+GUARD_W-1:0] a,
    input  logic [DATA_W-1:0]         b,
    input  logic                      sub,
    output logic [DATA_W+GUARD_W-1:0] y,
    output logic                      ovf
);

    localparam int W = DATA_W + GUARD_W;

    logic [W-1:0] b_ext;

    // Two's-complement add/subtract; overflow when the result sign disagrees with the operand signs.
    always_comb begin
        b_ext = {{GUARD_W{b[DATA_W-1]}}, b};
        y     = sub ? (a - b_ext) : (a + b_ext);
        if (sub) begin
            ovf = (a[W-1] != b_ext[W-1]) && (y[W-1] != a[W-1]);
        end else begin
            ovf = (a[W-1] == b_ext[W-1]) && (y[W-1] != a[W-1]);
        end
    end

endmodule

// File: rtl/pot_filter_alu.sv
// rtl/pot_filter_alu.sv - multi-channel POT accumulate/shift ALU (ALU_OVF_DETECT_EN adds sticky overflow flag)
module pot_filter_alu
    import alu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int GUARD_W     = DEF_GUARD_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int DATA_DEPTH  = DEF_DATA_DEPTH,
    parameter int COEFF_DEPTH = DEF_COEFF_DEPTH,
    parameter int N_RJ        = DEF_N_RJ,
    parameter int CHANNELS    = DEF_CHANNELS,
    localparam int DADDR_W    = $clog2(DATA_DEPTH),
    localparam int CADDR_W    = $clog2(COEFF_DEPTH),
    localparam int RADDR_W    = (N_RJ > 1) ? $clog2(N_RJ) : 1,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      start,
    input  logic [DADDR_W-1:0]        newest_addr,
    input  logic [DATA_W-1:0]         data,
    input  logic [DADDR_W:0]          coeff_data,
    input  logic [CADDR_W:0]          rj_data,
    output logic [CH_W+DADDR_W-1:0]   data_addr,
    output logic [CH_W+CADDR_W-1:0]   coeff_addr,
    output logic [CH_W+RADDR_W-1:0]   rj_addr,
    output logic                      busy,
    output logic [ACC_W-1:0]          result,
    output logic                      result_valid,
    output logic [CH_W-1:0]           result_ch,
    output logic                      done,
    output logic                      ovf
);

    localparam int TOP_W    = DATA_W + GUARD_W;
    localparam int SIGN_POS = COEFF_K_LSB + DADDR_W;

    alu_state_e state, state_nxt;

    logic [CH_W-1:0]           ch;
    logic [RADDR_W-1:0]        j;
    logic [CADDR_W:0]          u;
    logic [CADDR_W-1:0]        cidx;
    logic signed [ACC_W-1:0]   acc;

    logic [DADDR_W-1:0]        coeff_k;
    logic                      coeff_neg;
    logic [DADDR_W-1:0]        sample_idx;
    logic                      rj_zero;
    logic                      group_end;
    logic                      last_group;
    logic                      last_ch;
    logic [TOP_W-1:0]          top_sum;
    logic                      addsub_ovf;
    logic signed [ACC_W-1:0]   acc_pre;
    logic signed [ACC_W-1:0]   acc_nxt;

    assign coeff_k    = coeff_data[COEFF_K_LSB +: DADDR_W];
    assign coeff_neg  = coeff_data[SIGN_POS];
    assign sample_idx = newest_addr - coeff_k;
    assign rj_zero    = (rj_data == '0);
    assign group_end  = rj_zero || (u == (rj_data - (CADDR_W+1)'(1)));
    assign last_group = (j == RADDR_W'(N_RJ - 1));
    assign last_ch    = (ch == CH_W'(CHANNELS - 1));

    // The sample ring offset is only meaningful while accumulating; hold it at zero otherwise.
    assign data_addr  = {ch, (state == RUN) ? sample_idx : {DADDR_W{1'b0}}};
    assign coeff_addr = {ch, cidx};
    assign rj_addr    = {ch, j};

    pot_addsub #(
        .DATA_W  (DATA_W),
        .GUARD_W (GUARD_W)
    ) u_addsub (
        .a   (acc[ACC_W-1 -: TOP_W]),
        .b   (data),
        .sub (coeff_neg),
        .y   (top_sum),
        .ovf (addsub_ovf)
    );

    // Add into the top field (skipped for empty groups), then close the group with an arithmetic shift.
    always_comb begin
        acc_pre = rj_zero ? acc : {top_sum, acc[ACC_W-TOP_W-1:0]};
        acc_nxt = group_end ? (acc_pre >>> 1) : acc_pre;
    end

    // State register; clear dominates any concurrent start.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing and status outputs.
    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE);
        result_valid = 1'b0;
        done         = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN:  if (group_end && last_group) state_nxt = OUT;
            OUT: begin
                result_valid = 1'b1;
                done         = last_ch;
                state_nxt    = last_ch ? IDLE : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters and accumulator; the final accumulator value is captured on entry to OUT so it is
    // already on result while result_valid is high.
    always_ff @(posedge clk) begin
        if (clear) begin
            ch        <= '0;
            j         <= '0;
            u         <= '0;
            cidx      <= '0;
            acc       <= '0;
            result    <= '0;
            result_ch <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ch <= '0;
                end
                LOAD: begin
                    acc  <= '0;
                    j    <= '0;
                    u    <= '0;
                    cidx <= '0;
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (!rj_zero) begin
                        cidx <= cidx + CADDR_W'(1);
                    end
                    if (group_end) begin
                        u <= '0;
                        j <= j + RADDR_W'(1);
                    end else begin
                        u <= u + (CADDR_W+1)'(1);
                    end
                    if (group_end && last_group) begin
                        result    <= acc_nxt;
                        result_ch <= ch;
                    end
                end
                OUT: begin
                    ch <= last_ch ? '0 : ch + CH_W'(1);
                end
                default: ch <= '0;
            endcase
        end
    end

`ifdef ALU_OVF_DETECT_EN
    logic ovf_q;

    // Sticky overflow: set by any overflowing add/subtract, cleared by clear or an accepted start.
    always_ff @(posedge clk) begin
        if (clear) begin
            ovf_q <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && !rj_zero && addsub_ovf) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_addsub_ovf;
    assign unused_addsub_ovf = addsub_ovf;
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pot_filter_alu.sv
// tb/tb_pot_filter_alu.sv - scoreboard bench for pot_filter_alu with directed and random coefficient sets
module tb_pot_filter_alu;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [7:0]  newest_addr;
    logic [15:0] data;
    logic [8:0]  coeff_data;
    logic [9:0]  rj_data;
    logic [8:0]  data_addr;
    logic [9:0]  coeff_addr;
    logic [4:0]  rj_addr;
    logic        busy;
    logic [39:0] result;
    logic        result_valid;
    logic [0:0]  result_ch;
    logic        done;
    logic        ovf;

    logic [15:0] data_mem  [0:511];
    logic [8:0]  coeff_mem [0:1023];
    logic [9:0]  rj_mem    [0:31];

    assign data       = data_mem[data_addr];
    assign coeff_data = coeff_mem[coeff_addr];
    assign rj_data    = rj_mem[rj_addr];

    always #5 clk = ~clk;

    pot_filter_alu dut (
        .clk          (clk),
        .clear        (clear),
        .start        (start),
        .newest_addr  (newest_addr),
        .data         (data),
        .coeff_data   (coeff_data),
        .rj_data      (rj_data),
        .data_addr    (data_addr),
        .coeff_addr   (coeff_addr),
        .rj_addr      (rj_addr),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .done         (done),
        .ovf          (ovf)
    );

    typedef struct {
        logic [39:0] res;
        logic [0:0]  ch;
        logic        dn;
        logic        ov;
        int          at;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   busy_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: y = sum over groups of +/- x[n-k] in the top field, arithmetic shift closing each group.
    function automatic logic [40:0] model(input int ch);
        logic signed [39:0] acc;
        logic [23:0]        top;
        logic [8:0]         c;
        logic               ov;
        int                 s, ci, r, a;
        acc = '0; ci = 0; ov = 1'b0;
        for (int jj = 0; jj < 16; jj++) begin
            r = int'(rj_mem[ch*16 + jj]);
            if (r == 0) begin
                acc = acc >>> 1;
            end else begin
                for (int uu = 0; uu < r; uu++) begin
                    c  = coeff_mem[ch*512 + ci];
                    ci = (ci + 1) % 512;
                    a  = (int'(newest_addr) - int'(c[7:0])) & 255;
                    top = acc[39:16];
                    if (c[8]) s = int'($signed(top)) - int'($signed(data_mem[ch*256 + a]));
                    else      s = int'($signed(top)) + int'($signed(data_mem[ch*256 + a]));
                    if (s > 8388607 || s < -8388608) ov = 1'b1;
                    acc[39:16] = s[23:0];
                    if (uu == r - 1) acc = acc >>> 1;
                end
            end
        end
        return {ov, acc};
    endfunction

    function automatic int cycles(input int ch);
        int n = 2;
        for (int jj = 0; jj < 16; jj++) n += (rj_mem[ch*16 + jj] == 0) ? 1 : int'(rj_mem[ch*16 + jj]);
        return n;
    endfunction

    task automatic clr_mem();
        for (int i = 0; i < 512; i++)  data_mem[i]  = '0;
        for (int i = 0; i < 1024; i++) coeff_mem[i] = '0;
        for (int i = 0; i < 32; i++)   rj_mem[i]    = '0;
    endtask

    task automatic start_run(input bit push, input bit lit_en, input logic [39:0] lit0);
        logic [40:0] m;
        logic        ovacc;
        exp_t        e;
        int          at;
        @(posedge clk); #1;
        start = 1'b1;
        if (push) begin
            at = cyc; ovacc = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m = model(c);
                ovacc = ovacc | m[40];
                at += cycles(c);
                e.res = (lit_en && c == 0) ? lit0 : m[39:0];
                e.ch  = 1'(c);
                e.dn  = (c == 1);
`ifdef ALU_OVF_DETECT_EN
                e.ov  = ovacc;
`else
                e.ov  = 1'b0;
`endif
                e.at  = at;
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && q.size() != 0; i++) @(posedge clk);
        check("drain_timeout", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every result_valid pops one expected entry and checks value, channel, timing and flags.
    always @(negedge clk) begin
        exp_t e;
        if (busy_chk) begin
            check("busy_after_done", 64'(busy), 64'd0);
            busy_chk = 1'b0;
        end
        if (result_valid === 1'b1) begin
            check("unexpected_result", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("result_ch", 64'(result_ch), 64'(e.ch));
                check("done", 64'(done), 64'(e.dn));
                check("ovf", 64'(ovf), 64'(e.ov));
                check("latency", 64'(cyc), 64'(e.at));
                if (e.dn) busy_chk = 1'b1;
            end
        end
    end

    logic [40:0] m6;

    initial begin
        clear = 1'b1; start = 1'b0; newest_addr = '0;
        clr_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_ch", 64'(result_ch), 64'd0);
        check("rst_daddr", 64'(data_addr), 64'd0);
        check("rst_caddr", 64'(coeff_addr), 64'd0);
        check("rst_raddr", 64'(rj_addr), 64'd0);
        clear = 1'b0;

        // Single positive tap on ch0, mixed taps on ch1.
        rj_mem[0] = 10'd1; coeff_mem[0] = 9'h000; data_mem[0] = 16'h4000;
        rj_mem[16] = 10'd2; rj_mem[19] = 10'd1;
        coeff_mem[512] = {1'b0, 8'd1}; coeff_mem[513] = {1'b1, 8'd3}; coeff_mem[514] = {1'b0, 8'd0};
        data_mem[256] = 16'h0100; data_mem[256+255] = 16'h0700; data_mem[256+253] = 16'h0030;
        start_run(1'b1, 1'b1, 40'h00_0000_4000);
        wait_done();

        // Negative tap of +1 leaves all-ones after sixteen arithmetic shifts.
        coeff_mem[0] = {1'b1, 8'd0}; data_mem[0] = 16'h0001;
        start_run(1'b1, 1'b1, 40'hFF_FFFF_FFFF);
        wait_done();

        // Ring address wrap: newest 2, k 5 -> offset 253.
        clr_mem();
        newest_addr = 8'd2;
        rj_mem[0] = 10'd1; coeff_mem[0] = {1'b0, 8'd5};
        data_mem[253] = 16'h1234; data_mem[2] = 16'h5555;
        start_run(1'b1, 1'b1, 40'h00_0000_1234);
        @(posedge clk); #1;
        check("wrap_daddr", 64'(data_addr), 64'd253);
        wait_done();

        // Random groups on both channels, a long group forcing coefficient index wrap,
        // and a stray start while busy.
        newest_addr = 8'($urandom);
        for (int i = 0; i < 32; i++)   rj_mem[i]    = 10'($urandom_range(0, 3));
        for (int i = 0; i < 1024; i++) coeff_mem[i] = 9'($urandom);
        for (int i = 0; i < 512; i++)  data_mem[i]  = 16'($urandom);
        rj_mem[16+7] = 10'd520;
        start_run(1'b1, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done();

        // Clear mid-RUN together with start: clear wins, nothing is reported, then a clean rerun.
        start_run(1'b0, 1'b0, '0);
        repeat (5) @(posedge clk);
        #1; clear = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_daddr", 64'(data_addr), 64'd0);
        check("clr_caddr", 64'(coeff_addr), 64'd0);
        check("clr_raddr", 64'(rj_addr), 64'd0);
        clear = 1'b0; start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("clr_idle", 64'(busy), 64'd0);
        start_run(1'b1, 1'b0, '0);
        wait_done();

        // Top field 0x7FFF00 + 0xFF reaches 0x7FFFFF, then +1 overflows.
        clr_mem();
        newest_addr = 8'd10;
        rj_mem[0] = 10'd258;
        coeff_mem[256] = {1'b0, 8'd1}; coeff_mem[257] = {1'b0, 8'd2};
        data_mem[10] = 16'h7FFF; data_mem[9] = 16'h00FF; data_mem[8] = 16'h0001;
        m6 = model(0);
        start_run(1'b1, 1'b0, '0);
        wait_done();
`ifdef ALU_OVF_DETECT_EN
        check("ovf_held", 64'(ovf), 64'(m6[40]));
`else
        check("ovf_held", 64'(ovf), 64'd0);
`endif
        rj_mem[0] = 10'd1; coeff_mem[0] = 9'h000;
        start_run(1'b1, 1'b0, '0);
        check("ovf_cleared", 64'(ovf), 64'd0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pot_filter_alu.md
# pot_filter_alu

Parametrised multi-channel successor to the single-channel MSDAP accumulate/shift ALU. For each channel it computes y = Σ over N_RJ groups of (±x[n−k] partial sums) with a one-bit arithmetic right shift closing every group. Coefficients are powers-of-two (POT), each encoding a delay k and a sign. The block sits between the data/coefficient/Rj memories and the output serialiser, and is started once per input sample.

## Interface
- DATA_W, 16, input sample width
- GUARD_W, 8, guard bits above sample in adder
- ACC_W, 40, accumulator width (≥ DATA_W+GUARD_W)
- DATA_DEPTH, 256, per-channel sample ring depth (power of 2); DADDR_W = $clog2(DATA_DEPTH)
- COEFF_DEPTH, 512, per-channel coefficient words (power of 2); CADDR_W = $clog2(COEFF_DEPTH)
- N_RJ, 16, Rj groups per channel; RADDR_W = $clog2(N_RJ)
- CHANNELS, 2, channels processed per start; CH_W = max(1,$clog2(CHANNELS))
- clk  in  1  system clock (SCLK)
- clear  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a sample computation when idle
- newest_addr  in  DADDR_W  ring index of newest sample x[n] (common to all channels)
- data  in  DATA_W  sample at data_addr, same-cycle (asynchronous-read) memory
- coeff_data  in  DADDR_W+1  [DADDR_W-1:0]=k, [DADDR_W]=sign (1 = subtract)
- rj_data  in  CADDR_W+1  coefficient count of current group
- data_addr  out  CH_W+DADDR_W  {ch, newest_addr − k mod DATA_DEPTH}
- coeff_addr  out  CH_W+CADDR_W  {ch, coefficient index}
- rj_addr  out  CH_W+RADDR_W  {ch, group j}
- busy  out  1  high from cycle after accepted start until done
- result  out  ACC_W  channel result, held until next result_valid
- result_valid  out  1  one-cycle pulse per channel
- result_ch  out  CH_W  channel of result
- done  out  1  one-cycle pulse after last channel's result
- ovf  out  1  sticky accumulator overflow flag (see Configuration)

## Operation
- FSM states: IDLE, LOAD, RUN, OUT. IDLE→LOAD on start; LOAD→RUN; RUN→OUT after last cycle of group N_RJ−1; OUT→LOAD (next channel) or IDLE (last channel, done pulses in this OUT cycle).
- LOAD: accumulator ← 0, j ← 0, u ← 0, coefficient index ← 0.
- RUN, r_j ≥ 1: each cycle, top DATA_W+GUARD_W accumulator bits ← top ± sign-extended data; coefficient index and u increment. On the u = r_j−1 cycle, the add result is also shifted arithmetically right by one in the same cycle, then j increments and u ← 0.
- RUN, r_j = 0: one shift-only cycle, no add, no coefficient consumed.
- Coefficient index wraps modulo COEFF_DEPTH within the channel region; no error.
- Data address subtraction wraps modulo DATA_DEPTH.
- OUT: result ← accumulator, result_ch ← ch, result_valid = 1.
- start while busy: ignored. start and clear in the same cycle: clear wins.
- clear mid-operation: state IDLE, all counters 0 on the next edge; no result_valid/done.
- Reset values: busy, result_valid, done, ovf = 0; result = 0; result_ch = 0; all addresses = 0.

## Timing
- Cycles per channel = 2 + Σ_j max(r_j,1). Total latency = CHANNELS × that; done coincides with the last result_valid.
- Addresses are registered counters, combinationally mapped; memory data is used in the same cycle.
- busy falls the cycle after done.

## Configuration
- ALU_OVF_DETECT_EN defined: ovf is set when any add or subtract overflows the signed DATA_W+GUARD_W top field. It stays set until the next accepted start or clear. The wrapped value is kept; no saturation.
- Undefined: ovf is tied to 0 and there is no overflow logic.

## Structure
- Package alu_pkg: state enum (IDLE, LOAD, RUN, OUT), default parameter constants, coefficient-field position localparams.
- Sub-module pot_addsub: combinational sign-extend and add/subtract of width DATA_W+GUARD_W, with overflow output.

## Test plan
- CHANNELS=1, r_0=1, others 0, k=0, sign 0, x[n]=0x4000 -> result 0x0000004000 exactly 18 cycles after start.
- Same, but sign 1 and x[n]=0x0001 -> result 0xFFFFFFFFFF (arithmetic shift keeps sign).
- newest_addr=2, k=5 -> data_addr offset 253; sample at 253 is used.
- CHANNELS=2, distinct coefficients -> result_valid with result_ch 0 then 1; done with the second result; busy low on the next cycle.
- clear asserted mid-RUN -> IDLE on next edge, no result_valid; a following start gives a correct result.
- ALU_OVF_DETECT_EN, top field 0x7FFFFF + 0x0001 -> ovf=1, held through done, cleared by the next start.
